// File: rtl/mem_access_unit_pkg.sv
// Shared widths, opcode and state encodings for the memory access unit.
package mem_access_unit_pkg;

  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned INSTR_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF   = 15;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCESS   = 2'b01,
    ST_COMPLETE = 2'b10,
    ST_ERROR    = 2'b11
  } state_e;

  // Fetch and load both read memory; store is the only write.
  function automatic logic op_is_read(op_e op);
    return (op == OP_FETCH) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// Wait counter for memory acknowledge; expired when TIMEOUT_CYCLES-1 cycles elapsed.
module timeout_counter
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Next count: clear wins, otherwise advance while enabled and not at limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: performs one fetch/load/store per request with ack timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDRESS_BUS_WIDTH = ADDR_W_DEF,
  parameter int unsigned DATA_BUS_WIDTH    = DATA_W_DEF,
  parameter int unsigned INSTRUCTION_WIDTH = INSTR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0]    mem_wdata,
  output logic                         mem_rd,
  output logic                         mem_wr,
  input  logic                         mem_ack,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] ir_data,
  output logic                         ir_enable,
  output logic [DATA_BUS_WIDTH-1:0]    mdr_data,
  output logic                         mdr_enable,
  output logic                         done,
  output logic                         err,
  output logic                         busy
);

  state_e                         state_q, state_d;
  op_e                            op_q, op_d;
  logic [ADDRESS_BUS_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0]      wdata_q, wdata_d;
  logic [INSTRUCTION_WIDTH-1:0]   ir_q, ir_d;
  logic [DATA_BUS_WIDTH-1:0]      mdr_q, mdr_d;
  logic                           cnt_clear, cnt_en, cnt_expired;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .expired_o(cnt_expired)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ir_data   = ir_q;
  assign mdr_data  = mdr_q;

  // Read data is written straight into IR/MDR on the ack edge, so the value is
  // already presented during COMPLETE and simply holds afterwards.
  // Next-state, datapath latching and output decode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    cnt_clear  = 1'b1;
    cnt_en     = 1'b0;
    req_ready  = 1'b0;
    busy       = 1'b1;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    ir_enable  = 1'b0;
    mdr_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = (op_e'(req_op) == OP_RSVD) ? ST_ERROR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_rd    = op_is_read(op_q);
        mem_wr    = (op_q == OP_STORE);
        cnt_clear = 1'b0;
        if (mem_ack) begin
          cnt_clear = 1'b1;
          if (op_q == OP_FETCH) ir_d = mem_rdata[INSTRUCTION_WIDTH-1:0];
          if (op_q == OP_LOAD)  mdr_d = mem_rdata;
          state_d = ST_COMPLETE;
        end else if (cnt_expired) begin
          state_d = ST_ERROR;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_COMPLETE: begin
        done       = 1'b1;
        ir_enable  = (op_q == OP_FETCH);
        mdr_enable = (op_q == OP_LOAD);
        state_d    = ST_IDLE;
      end
      ST_ERROR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: per-transaction timeline model plus directed cases.
module tb_mem_access_unit;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir_data, mdr_data;
  logic        ir_enable, mdr_enable, done, err, busy;

  mem_access_unit #(
    .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH   (16),
    .INSTRUCTION_WIDTH(16),
    .TIMEOUT_CYCLES   (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_data   (ir_data),
    .ir_enable (ir_enable),
    .mdr_data  (mdr_data),
    .mdr_enable(mdr_enable),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready, busy, rd, wr, done, err, ir_en, mdr_en;
    logic [15:0] addr, wdata, ir, mdr;
  } exp_t;

  exp_t        ex;
  bit          ex_valid = 1'b0;
  logic [15:0] ir_m = '0, mdr_m = '0;
  int          tests = 0, failed = 0;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0;
  int          n_done = 0, n_err = 0, n_wr = 0, n_rd = 0, n_ir = 0, n_mdr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // kind: 0 idle, 1 access, 2 complete, 3 error
  function automatic exp_t mk(int kind, logic [1:0] op, logic [15:0] a, logic [15:0] w);
    exp_t e;
    e = '0;
    e.ir = ir_m;
    e.mdr = mdr_m;
    e.addr = a;
    e.wdata = w;
    case (kind)
      0: e.ready = 1'b1;
      1: begin e.busy = 1'b1; e.rd = (op != 2'd2); e.wr = (op == 2'd2); end
      2: begin e.busy = 1'b1; e.done = 1'b1; e.ir_en = (op == 2'd0); e.mdr_en = (op == 2'd1); end
      default: begin e.busy = 1'b1; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT events and compare every cycle against the expected timeline.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) n_err++;
      if (mem_wr) n_wr++;
      if (mem_rd) n_rd++;
      if (ir_enable) n_ir++;
      if (mdr_enable) n_mdr++;
      if (ex_valid) begin
        chk("req_ready", req_ready, ex.ready);
        chk("busy", busy, ex.busy);
        chk("mem_rd", mem_rd, ex.rd);
        chk("mem_wr", mem_wr, ex.wr);
        chk("done", done, ex.done);
        chk("err", err, ex.err);
        chk("ir_enable", ir_enable, ex.ir_en);
        chk("mdr_enable", mdr_enable, ex.mdr_en);
        chk("ir_data", ir_data, ex.ir);
        chk("mdr_data", mdr_data, ex.mdr);
        if (ex.rd || ex.wr) chk("mem_addr", mem_addr, ex.addr);
        if (ex.wr) chk("mem_wdata", mem_wdata, ex.wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_req();
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 2'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ex = mk(0, 2'd0, 16'h0, 16'h0);
      req_valid = 1'b0;
      req_op = 2'($urandom);
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      step();
    end
    mem_ack = 1'b0;
  endtask

  // delay = number of ACCESS cycles without ack before the ack cycle (>= T means never)
  task automatic do_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] w,
                        input int delay, input logic [15:0] rd);
    ex = mk(0, op, a, w);
    req_valid = 1'b1;
    req_op = op;
    req_addr = a;
    req_wdata = w;
    mem_ack = 1'($urandom_range(0, 1));
    step();
    acc_cyc = cyc;
    if (op == 2'd3) begin
      scramble_req();
      mem_ack = 1'b0;
      ex = mk(3, op, a, w);
      step();
    end else begin
      for (int i = 0; i < T; i++) begin
        scramble_req();
        ex = mk(1, op, a, w);
        mem_ack = (i == delay);
        mem_rdata = (i == delay) ? rd : 16'($urandom);
        step();
        if (i == delay) begin
          if (op == 2'd0) ir_m = rd;
          if (op == 2'd1) mdr_m = rd;
          ex = mk(2, op, a, w);
          scramble_req();
          mem_ack = 1'($urandom_range(0, 1));
          step();
          break;
        end else if (i == T - 1) begin
          ex = mk(3, op, a, w);
          scramble_req();
          mem_ack = 1'($urandom_range(0, 1));
          step();
        end
      end
    end
    req_valid = 1'b0;
    mem_ack = 1'b0;
    ex = mk(0, 2'd0, 16'h0, 16'h0);
  endtask

  initial begin
    int d0, e0, w0, r0, i0, m0, dly;
    logic [1:0] op;

    // Reset state
    #2;
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst ir_data", ir_data, 0);
    chk("rst mdr_data", mdr_data, 0);
    #6 rst_n = 1'b1;
    step();
    chk("rst req_ready", req_ready, 1);
    chk("rst busy", busy, 0);
    ex = mk(0, 2'd0, 16'h0, 16'h0);
    ex_valid = 1'b1;
    idle_cycles(2);

    // Fetch with three wait cycles
    d0 = n_done; m0 = n_mdr; i0 = n_ir;
    do_txn(2'd0, 16'h0010, 16'h0, 3, 16'hA5C3);
    chk("fetch ir_data", ir_data, 16'hA5C3);
    chk("fetch done count", n_done - d0, 1);
    chk("fetch ir_enable count", n_ir - i0, 1);
    chk("fetch mdr_enable count", n_mdr - m0, 0);

    // Load acked on first ACCESS cycle
    do_txn(2'd1, 16'h0200, 16'h0, 0, 16'h1234);
    chk("load mdr_data", mdr_data, 16'h1234);
    chk("load accept-to-done", done_cyc + 1 - acc_cyc, 2);

    // Store that never gets acked
    d0 = n_done; e0 = n_err; w0 = n_wr;
    do_txn(2'd2, 16'h0300, 16'hBEEF, T + 5, 16'h0);
    chk("store wr cycles", n_wr - w0, 15);
    chk("store err count", n_err - e0, 1);
    chk("store done count", n_done - d0, 0);
    chk("store ready after err", req_ready, 1);

    // Ack exactly on the last allowed ACCESS cycle
    d0 = n_done; e0 = n_err;
    do_txn(2'd0, 16'h0444, 16'h0, T - 1, 16'h5A5A);
    chk("late ack done", n_done - d0, 1);
    chk("late ack err", n_err - e0, 0);

    // Reserved opcode
    e0 = n_err; w0 = n_wr; r0 = n_rd;
    do_txn(2'd3, 16'h0555, 16'h0, 0, 16'h0);
    chk("rsvd err count", n_err - e0, 1);
    chk("rsvd strobes", (n_wr - w0) + (n_rd - r0), 0);

    // Stray acks while idle
    d0 = n_done; i0 = n_ir; m0 = n_mdr;
    idle_cycles(6);
    chk("stray done", n_done - d0, 0);
    chk("stray enables", (n_ir - i0) + (n_mdr - m0), 0);

    // Reset in the middle of a load
    d0 = n_done; e0 = n_err;
    ex = mk(0, 2'd1, 16'h0400, 16'h0);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 16'h0400;
    step();
    req_valid = 1'b0;
    ex = mk(1, 2'd1, 16'h0400, 16'h0);
    step();
    #2;
    ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst mem_rd", mem_rd, 0);
    chk("midrst mem_wr", mem_wr, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    chk("midrst mdr_data", mdr_data, 0);
    chk("midrst busy", busy, 0);
    ir_m = '0; mdr_m = '0;
    mem_ack = 1'b1;
    @(posedge clk);
    #3;
    mem_ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk("midrst ready", req_ready, 1);
    ex = mk(0, 2'd0, 16'h0, 16'h0);
    ex_valid = 1'b1;
    do_txn(2'd1, 16'h0404, 16'h0, 1, 16'h7E57);
    chk("post-rst mdr_data", mdr_data, 16'h7E57);
    chk("midrst no err", n_err - e0, 0);
    chk("post-rst done count", n_done - d0, 1);

    // Randomized traffic, back-to-back with occasional idle gaps
    for (int k = 0; k < 80; k++) begin
      int r;
      op = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 6)      dly = $urandom_range(0, 5);
      else if (r < 8) dly = T - 1;
      else            dly = T + $urandom_range(0, 3);
      do_txn(op, 16'($urandom), 16'($urandom), dly, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    ex_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
